// File: rtl/coda_pkg.sv
// Shared width helper and default geometry for the register FIFO.
package coda_pkg;

    // Width needed to index or count x values, never less than one bit.
    function automatic int clog2_min1(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

    localparam int DEF_N     = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_PW    = clog2_min1(DEF_DEPTH);
    localparam int DEF_CW    = clog2_min1(DEF_DEPTH + 1);

endpackage

// File: rtl/coda_cella.sv
// One N-bit storage cell with load enable; cleared asynchronously.
// Latency 1 from enable to q; no handshake of its own.
module coda_cella #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/coda_registri.sv
// Register FIFO of DEPTH entries with valid/ready on both sides and synchronous flush.
// Write-to-read latency 1, no bypass; ready/valid decoded from registered count only.
module coda_registri
    import coda_pkg::*;
#(
    parameter  int N     = DEF_N,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PW    = clog2_min1(DEPTH),
    localparam int CW    = clog2_min1(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  ent_q [DEPTH];
    logic          push, pop, wr_en;

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        coda_cella #(.N(N)) u_cella (
            .clock  (clock),
            .reset  (reset),
            .enable (wr_en && (wr_ptr_q == PW'(i))),
            .d      (in_data),
            .q      (ent_q[i])
        );
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr_q == PW'(i)) out_data = ent_q[i];
        end
    end

endmodule
